// File: rtl/cache_pkg.sv
// Shared types for the last-level cache model: command codes, MESI states,
// bus operations and snoop responses.
package cache_pkg;

  localparam int CACHE_ADR_BITS = 32;
  localparam int CMD_SIZE       = 4;

  typedef enum logic [CMD_SIZE-1:0] {
    CPU_READ         = 4'd0,
    CPU_WRITE        = 4'd1,
    INSTR_READ       = 4'd2,
    SNOOP_INVALIDATE = 4'd3,
    SNOOP_READ       = 4'd4,
    SNOOP_WRITE      = 4'd5,
    SNOOP_RWIM       = 4'd6,
    CLEAR            = 4'd8,
    PRINT            = 4'd9
  } cmd_t;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    BUS_NONE       = 2'd0,
    BUS_READ       = 2'd1,
    BUS_RWIM       = 2'd2,
    BUS_INVALIDATE = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_rsp_t;

  // Another cache holding the line forces our fill into Shared.
  function automatic mesi_t fill_state(input logic [1:0] snoop_in);
    return (snoop_in == SNP_HIT || snoop_in == SNP_HITM) ? MESI_S : MESI_E;
  endfunction

endpackage

// File: rtl/llc_plru.sv
// Tree pseudo-LRU for one set: heap-ordered node bits (node n at tree[n-1]),
// bit 0 steers the victim search to the lower half.
module llc_plru #(
  parameter int WAYS = 8,
  localparam int WL = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] tree,
  input  logic [WL-1:0]   access_way,
  output logic [WL-1:0]   victim_way,
  output logic [WAYS-2:0] tree_next
);

  logic [WAYS-1:0] tree_ext;
  logic [WAYS-1:0] next_ext;
  logic [WL:0]     vic_node;
  logic [WL:0]     upd_node;
  logic [WL-1:0]   way_sh;

  assign tree_ext = {tree, 1'b0};

  // Walk root to leaf following the bits; the leaf number minus WAYS is the way.
  always_comb begin
    vic_node    = '0;
    vic_node[0] = 1'b1;
    for (int l = 0; l < WL; l++) begin
      vic_node = {vic_node[WL-1:0], tree_ext[vic_node[WL-1:0]]};
    end
    victim_way = vic_node[WL-1:0];
  end

  // Walk the accessed way's path, flipping each node to point at the other half.
  always_comb begin
    next_ext    = tree_ext;
    upd_node    = '0;
    upd_node[0] = 1'b1;
    way_sh      = access_way;
    for (int l = 0; l < WL; l++) begin
      next_ext[upd_node[WL-1:0]] = ~way_sh[WL-1];
      upd_node = {upd_node[WL-1:0], way_sh[WL-1]};
      way_sh   = way_sh << 1;
    end
    tree_next = next_ext[WAYS-1:1];
  end

endmodule

// File: rtl/llc_cache.sv
// Tag/state-only MESI last-level cache: one command per clock, registered
// response one cycle later, tree-PLRU replacement per set.
module llc_cache
  import cache_pkg::*;
#(
  parameter int ADR_BITS   = CACHE_ADR_BITS,
  parameter int LINE_BYTES = 64,
  parameter int SETS       = 256,
  parameter int WAYS       = 8,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  input  logic [CMD_SIZE-1:0] cmd,
  input  logic [ADR_BITS-1:0] addr,
  input  logic [1:0]          snoop_in,
  output logic                rsp_valid,
  output logic                hit,
  output logic                miss,
  output logic [1:0]          bus_op,
  output logic [ADR_BITS-1:0] bus_addr,
  output logic                wb_valid,
  output logic [ADR_BITS-1:0] wb_addr,
  output logic [1:0]          snoop_rsp,
  output logic [CNT_W-1:0]    read_cnt,
  output logic [CNT_W-1:0]    write_cnt,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADR_BITS - OFF - IDX;
  localparam int WL    = $clog2(WAYS);

  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  mesi_t            state_reg [SETS][WAYS];
  logic [WAYS-2:0]  plru_reg  [SETS];

  logic [IDX-1:0]      idx;
  logic [TAG_W-1:0]    tag;
  logic [ADR_BITS-1:0] line_addr;
  logic                unused_offset;

  assign idx           = addr[OFF+IDX-1:OFF];
  assign tag           = addr[ADR_BITS-1:OFF+IDX];
  assign line_addr     = {addr[ADR_BITS-1:OFF], {OFF{1'b0}}};
  assign unused_offset = ^addr[OFF-1:0];

  logic [WAYS-1:0] hit_vec;
  logic [WAYS-1:0] inv_vec;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign hit_vec[gi] = (state_reg[idx][gi] != MESI_I) && (tag_mem[idx][gi] == tag);
      assign inv_vec[gi] = (state_reg[idx][gi] == MESI_I);
    end
  endgenerate

  logic [WL-1:0] hit_way;
  logic [WL-1:0] inv_way;

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WL'(w);
      if (inv_vec[w]) inv_way = WL'(w);
    end
  end

  logic            line_hit;
  logic [WL-1:0]   plru_victim;
  logic [WL-1:0]   victim_way;
  logic [WL-1:0]   access_way;
  logic [WAYS-2:0] plru_next;
  mesi_t           hit_state;
  mesi_t           victim_state;
  logic [TAG_W-1:0] victim_tag;
  logic            cpu_cmd;

  assign line_hit     = |hit_vec;
  assign victim_way   = (|inv_vec) ? inv_way : plru_victim;
  assign access_way   = line_hit ? hit_way : victim_way;
  assign hit_state    = state_reg[idx][hit_way];
  assign victim_state = state_reg[idx][victim_way];
  assign victim_tag   = tag_mem[idx][victim_way];
  assign cpu_cmd      = (cmd == CPU_READ) || (cmd == INSTR_READ) || (cmd == CPU_WRITE);

  llc_plru #(.WAYS(WAYS)) u_plru (
    .tree       (plru_reg[idx]),
    .access_way (access_way),
    .victim_way (plru_victim),
    .tree_next  (plru_next)
  );

  // Tags need no reset: a line's tag only matters while its state is valid.
  always_ff @(posedge clk) begin
    if (cmd_valid && cpu_cmd && !line_hit) begin
      tag_mem[idx][victim_way] <= tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) state_reg[s][w] <= MESI_I;
      end
      rsp_valid <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      bus_op    <= BUS_NONE;
      bus_addr  <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      snoop_rsp <= SNP_NOHIT;
      read_cnt  <= '0;
      write_cnt <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      bus_op    <= BUS_NONE;
      bus_addr  <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      snoop_rsp <= SNP_NOHIT;
      if (cmd_valid) begin
        case (cmd)
          CPU_READ, INSTR_READ, CPU_WRITE: begin
            rsp_valid     <= 1'b1;
            plru_reg[idx] <= plru_next;
            if (cmd == CPU_WRITE) begin
              if (~&write_cnt) write_cnt <= write_cnt + CNT_W'(1);
            end else begin
              if (~&read_cnt) read_cnt <= read_cnt + CNT_W'(1);
            end
            if (line_hit) begin
              hit <= 1'b1;
              if (~&hit_cnt) hit_cnt <= hit_cnt + CNT_W'(1);
              if (cmd == CPU_WRITE) begin
                // Shared copies elsewhere must be killed before we own the line.
                if (hit_state == MESI_S) begin
                  bus_op   <= BUS_INVALIDATE;
                  bus_addr <= line_addr;
                end
                state_reg[idx][hit_way] <= MESI_M;
              end
            end else begin
              miss     <= 1'b1;
              bus_addr <= line_addr;
              if (~&miss_cnt) miss_cnt <= miss_cnt + CNT_W'(1);
              if (victim_state == MESI_M) begin
                wb_valid <= 1'b1;
                wb_addr  <= {victim_tag, idx, {OFF{1'b0}}};
              end
              if (cmd == CPU_WRITE) begin
                bus_op                     <= BUS_RWIM;
                state_reg[idx][victim_way] <= MESI_M;
              end else begin
                bus_op                     <= BUS_READ;
                state_reg[idx][victim_way] <= fill_state(snoop_in);
              end
            end
          end
          SNOOP_READ, SNOOP_RWIM: begin
            rsp_valid <= 1'b1;
            if (line_hit) begin
              snoop_rsp <= (hit_state == MESI_M) ? SNP_HITM : SNP_HIT;
              if (hit_state == MESI_M) begin
                wb_valid <= 1'b1;
                wb_addr  <= line_addr;
              end
              state_reg[idx][hit_way] <= (cmd == SNOOP_READ) ? MESI_S : MESI_I;
            end
          end
          SNOOP_INVALIDATE: begin
            rsp_valid <= 1'b1;
            if (line_hit && hit_state == MESI_S) begin
              snoop_rsp               <= SNP_HIT;
              state_reg[idx][hit_way] <= MESI_I;
            end
          end
          SNOOP_WRITE, PRINT: begin
            rsp_valid <= 1'b1;
          end
          CLEAR: begin
            rsp_valid <= 1'b1;
            for (int s = 0; s < SETS; s++) begin
              plru_reg[s] <= '0;
              for (int w = 0; w < WAYS; w++) state_reg[s][w] <= MESI_I;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_llc_cache.sv
// Self-checking bench for llc_cache: directed scenarios plus a randomized
// stream checked against a recency-based MESI/PLRU reference model.
module tb_llc_cache;

  localparam int AW   = 32;
  localparam int SETS = 256;
  localparam int WAYS = 8;
  localparam int CW   = 32;

  localparam int ST_I = 0, ST_S = 1, ST_E = 2, ST_M = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic [AW-1:0] addr = '0;
  logic [1:0]    snoop_in = 2'd0;
  logic          rsp_valid, hit, miss, wb_valid;
  logic [1:0]    bus_op, snoop_rsp;
  logic [AW-1:0] bus_addr, wb_addr;
  logic [CW-1:0] read_cnt, write_cnt, hit_cnt, miss_cnt;

  llc_cache #(.ADR_BITS(AW), .LINE_BYTES(64), .SETS(SETS), .WAYS(WAYS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .addr(addr),
    .snoop_in(snoop_in), .rsp_valid(rsp_valid), .hit(hit), .miss(miss),
    .bus_op(bus_op), .bus_addr(bus_addr), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .snoop_rsp(snoop_rsp), .read_cnt(read_cnt), .write_cnt(write_cnt),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: per-line state/tag and a last-touch timestamp per way.
  int          m_state [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  int          m_ts    [SETS][WAYS];
  int          m_time;
  int unsigned m_rd, m_wr, m_hit, m_miss;

  logic          e_rsp, e_hit, e_miss, e_wb;
  logic [1:0]    e_bus, e_snp;
  logic [AW-1:0] e_bus_addr, e_wb_addr;

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_state[s][w] = ST_I;
        m_ts[s][w] = 0;
      end
    m_time = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
  endtask

  // At each subtree, steer away from the half holding the most recent access.
  function automatic int plru_victim(input int s);
    int lo = 0;
    int size = WAYS;
    int ml, mu;
    while (size > 1) begin
      ml = 0; mu = 0;
      for (int i = 0; i < size / 2; i++) begin
        if (m_ts[s][lo+i] > ml) ml = m_ts[s][lo+i];
        if (m_ts[s][lo+size/2+i] > mu) mu = m_ts[s][lo+size/2+i];
      end
      if (ml > mu) lo = lo + size / 2;
      size = size / 2;
    end
    return lo;
  endfunction

  task automatic touch(input int s, input int w);
    m_time++;
    m_ts[s][w] = m_time;
  endtask

  task automatic model_alloc(input int s, input int unsigned t, output int v);
    v = -1;
    for (int i = WAYS - 1; i >= 0; i--) if (m_state[s][i] == ST_I) v = i;
    if (v < 0) v = plru_victim(s);
    if (m_state[s][v] == ST_M) begin
      e_wb = 1'b1;
      e_wb_addr = (m_tag[s][v] << 14) | (32'(s) << 6);
    end
    m_tag[s][v] = t;
  endtask

  task automatic model_exec(input logic [3:0] c, input logic [31:0] a, input logic [1:0] snp);
    int s, w, v;
    int unsigned t;
    logic [31:0] la;
    s = int'((a >> 6) & 32'hFF);
    t = a >> 14;
    la = a & ~32'h3F;
    e_rsp = 0; e_hit = 0; e_miss = 0; e_wb = 0; e_bus = 2'd0; e_snp = 2'd0;
    e_bus_addr = '0; e_wb_addr = '0;
    w = -1;
    for (int i = 0; i < WAYS; i++) if (m_state[s][i] != ST_I && m_tag[s][i] == t) w = i;
    case (c)
      4'd0, 4'd2: begin
        e_rsp = 1; m_rd++;
        if (w >= 0) begin e_hit = 1; m_hit++; touch(s, w); end
        else begin
          e_miss = 1; m_miss++; e_bus = 2'd1; e_bus_addr = la;
          model_alloc(s, t, v);
          m_state[s][v] = (snp == 2'd1 || snp == 2'd2) ? ST_S : ST_E;
          touch(s, v);
        end
      end
      4'd1: begin
        e_rsp = 1; m_wr++;
        if (w >= 0) begin
          e_hit = 1; m_hit++;
          if (m_state[s][w] == ST_S) begin e_bus = 2'd3; e_bus_addr = la; end
          m_state[s][w] = ST_M; touch(s, w);
        end else begin
          e_miss = 1; m_miss++; e_bus = 2'd2; e_bus_addr = la;
          model_alloc(s, t, v);
          m_state[s][v] = ST_M; touch(s, v);
        end
      end
      4'd4, 4'd6: begin
        e_rsp = 1;
        if (w >= 0) begin
          if (m_state[s][w] == ST_M) begin e_snp = 2'd2; e_wb = 1; e_wb_addr = la; end
          else e_snp = 2'd1;
          m_state[s][w] = (c == 4'd4) ? ST_S : ST_I;
        end
      end
      4'd3: begin
        e_rsp = 1;
        if (w >= 0 && m_state[s][w] == ST_S) begin e_snp = 2'd1; m_state[s][w] = ST_I; end
      end
      4'd5, 4'd9: e_rsp = 1;
      4'd8: begin e_rsp = 1; model_clear(); end
      default: ;
    endcase
  endtask

  task automatic apply(input logic [3:0] c, input logic [31:0] a, input logic [1:0] snp);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; addr = a; snoop_in = snp;
    model_exec(c, a, snp);
    @(posedge clk); #1;
    $display("[TB] cmd=%0d addr=%08h snp=%0d -> rsp=%0b hit=%0b miss=%0b bus=%0d@%08h wb=%0b@%08h srsp=%0d cnt=%0d/%0d/%0d/%0d",
             c, a, snp, rsp_valid, hit, miss, bus_op, bus_addr, wb_valid, wb_addr, snoop_rsp,
             read_cnt, write_cnt, hit_cnt, miss_cnt);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 4'd0; addr = '0; snoop_in = 2'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp: got %0b want 0", rsp_valid); end
    tests_run++; if ({read_cnt, write_cnt, hit_cnt, miss_cnt} !== '0) begin tests_failed++; $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d want 0", read_cnt, write_cnt, hit_cnt, miss_cnt); end
    tests_run++; if ({bus_op, wb_valid, snoop_rsp, hit, miss} !== '0) begin tests_failed++; $display("FAIL reset_out: bus=%0d wb=%0b srsp=%0d want 0", bus_op, wb_valid, snoop_rsp); end
  endtask

  task automatic test_read_hit();
    apply(4'd0, 32'h0000_1000, 2'd0);
    tests_run++; if (miss !== 1'b1 || bus_op !== 2'd1) begin tests_failed++; $display("FAIL read_miss: miss=%0b bus=%0d want 1/1", miss, bus_op); end
    tests_run++; if (bus_addr !== 32'h0000_1000) begin tests_failed++; $display("FAIL read_bus_addr: got %08h want 00001000", bus_addr); end
    apply(4'd0, 32'h0000_1000, 2'd0);
    tests_run++; if (hit !== 1'b1 || hit_cnt !== 32'd1 || read_cnt !== 32'd2) begin tests_failed++; $display("FAIL read_hit: hit=%0b hit_cnt=%0d read_cnt=%0d want 1/1/2", hit, hit_cnt, read_cnt); end
    apply(4'd4, 32'h0000_1000, 2'd0);
    tests_run++; if (snoop_rsp !== 2'd1 || wb_valid !== 1'b0) begin tests_failed++; $display("FAIL snoop_read_e: rsp=%0d wb=%0b want 1/0", snoop_rsp, wb_valid); end
    apply(4'd3, 32'h0000_1000, 2'd0);
    tests_run++; if (snoop_rsp !== 2'd1) begin tests_failed++; $display("FAIL snoop_inv_s: got %0d want 1", snoop_rsp); end
    apply(4'd3, 32'h0000_1000, 2'd0);
    tests_run++; if (snoop_rsp !== 2'd0) begin tests_failed++; $display("FAIL snoop_inv_i: got %0d want 0", snoop_rsp); end
  endtask

  task automatic test_shared_write();
    apply(4'd0, 32'h2000_0040, 2'd1);
    tests_run++; if (miss !== 1'b1 || bus_op !== 2'd1) begin tests_failed++; $display("FAIL shared_fill: miss=%0b bus=%0d want 1/1", miss, bus_op); end
    apply(4'd1, 32'h2000_0040, 2'd0);
    tests_run++; if (bus_op !== 2'd3 || bus_addr !== 32'h2000_0040) begin tests_failed++; $display("FAIL write_s_inval: bus=%0d@%08h want 3@20000040", bus_op, bus_addr); end
    tests_run++; if (hit !== 1'b1 || write_cnt !== 32'd1) begin tests_failed++; $display("FAIL write_s_hit: hit=%0b write_cnt=%0d want 1/1", hit, write_cnt); end
  endtask

  task automatic test_snoop();
    apply(4'd4, 32'h2000_0040, 2'd0);
    tests_run++; if (snoop_rsp !== 2'd2 || wb_valid !== 1'b1 || wb_addr !== 32'h2000_0040) begin tests_failed++; $display("FAIL snoop_read_m: rsp=%0d wb=%0b@%08h want 2/1@20000040", snoop_rsp, wb_valid, wb_addr); end
    apply(4'd6, 32'h2000_0047, 2'd0);
    tests_run++; if (snoop_rsp !== 2'd1 || wb_valid !== 1'b0) begin tests_failed++; $display("FAIL snoop_rwim_s: rsp=%0d wb=%0b want 1/0", snoop_rsp, wb_valid); end
    apply(4'd0, 32'h2000_0040, 2'd0);
    tests_run++; if (miss !== 1'b1) begin tests_failed++; $display("FAIL after_rwim_miss: got %0b want 1", miss); end
  endtask

  task automatic test_eviction();
    for (int t = 1; t <= WAYS; t++) begin
      apply(4'd1, 32'(t) << 14, 2'd0);
      tests_run++; if (bus_op !== 2'd2 || wb_valid !== 1'b0) begin tests_failed++; $display("FAIL fill_%0d: bus=%0d wb=%0b want 2/0", t, bus_op, wb_valid); end
    end
    apply(4'd1, 32'(WAYS + 1) << 14, 2'd0);
    tests_run++; if (wb_valid !== 1'b1 || wb_addr !== 32'h0000_4000) begin tests_failed++; $display("FAIL evict_way0: wb=%0b@%08h want 1@00004000", wb_valid, wb_addr); end
    // Touch way 1, leaving way 4 (tag 5) as the pseudo-LRU victim.
    apply(4'd0, 32'h0000_8000, 2'd0);
    tests_run++; if (hit !== 1'b1) begin tests_failed++; $display("FAIL evict_rehit: got %0b want 1", hit); end
    apply(4'd1, 32'd10 << 14, 2'd0);
    tests_run++; if (wb_valid !== 1'b1 || wb_addr !== 32'h0001_4000) begin tests_failed++; $display("FAIL evict_way4: wb=%0b@%08h want 1@00014000", wb_valid, wb_addr); end
  endtask

  task automatic test_clear();
    apply(4'd8, 32'h0, 2'd0);
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL clear_rsp: got %0b want 1", rsp_valid); end
    tests_run++; if (read_cnt !== m_rd || write_cnt !== m_wr || hit_cnt !== m_hit || miss_cnt !== m_miss) begin tests_failed++; $display("FAIL clear_cnt: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", read_cnt, write_cnt, hit_cnt, miss_cnt, m_rd, m_wr, m_hit, m_miss); end
    apply(4'd0, 32'h0000_8000, 2'd0);
    tests_run++; if (miss !== 1'b1 || wb_valid !== 1'b0) begin tests_failed++; $display("FAIL clear_miss: miss=%0b wb=%0b want 1/0", miss, wb_valid); end
  endtask

  task automatic test_illegal();
    logic [3:0] codes [3];
    codes[0] = 4'd7; codes[1] = 4'd10; codes[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      apply(codes[i], 32'h0000_8000, 2'd0);
      tests_run++; if (rsp_valid !== 1'b0 || read_cnt !== m_rd) begin tests_failed++; $display("FAIL illegal_%0d: rsp=%0b read_cnt=%0d want 0/%0d", codes[i], rsp_valid, read_cnt, m_rd); end
    end
    apply(4'd0, 32'h0000_8000, 2'd0);
    tests_run++; if (hit !== 1'b1) begin tests_failed++; $display("FAIL illegal_nochange: hit=%0b want 1", hit); end
    idle();
    @(posedge clk); #1;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_rsp: got %0b want 0", rsp_valid); end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned t, s;
    t = $urandom_range(0, 11) * 32'h1111;
    s = $urandom_range(0, 2);
    return (t << 14) | (s << 6) | $urandom_range(0, 63);
  endfunction

  task automatic test_random();
    logic [3:0] c;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30) c = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd2;
      else if (r < 55) c = 4'd1;
      else if (r < 65) c = 4'd4;
      else if (r < 72) c = 4'd6;
      else if (r < 78) c = 4'd3;
      else if (r < 82) c = 4'd5;
      else if (r < 85) c = 4'd9;
      else if (r < 86) c = 4'd8;
      else if (r < 90) c = 4'(($urandom_range(0, 5) == 0) ? 7 : $urandom_range(10, 15));
      else c = 4'd0;
      apply(c, rand_addr(), 2'($urandom_range(0, 2)));
      tests_run++;
      if (rsp_valid !== e_rsp || hit !== e_hit || miss !== e_miss || bus_op !== e_bus ||
          bus_addr !== e_bus_addr || wb_valid !== e_wb || wb_addr !== e_wb_addr || snoop_rsp !== e_snp) begin
        tests_failed++;
        $display("FAIL rand_%0d rsp: got v%0b h%0b m%0b bus%0d@%08h wb%0b@%08h s%0d want v%0b h%0b m%0b bus%0d@%08h wb%0b@%08h s%0d",
                 n, rsp_valid, hit, miss, bus_op, bus_addr, wb_valid, wb_addr, snoop_rsp,
                 e_rsp, e_hit, e_miss, e_bus, e_bus_addr, e_wb, e_wb_addr, e_snp);
      end
      tests_run++;
      if (read_cnt !== m_rd || write_cnt !== m_wr || hit_cnt !== m_hit || miss_cnt !== m_miss) begin
        tests_failed++;
        $display("FAIL rand_%0d cnt: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", n,
                 read_cnt, write_cnt, hit_cnt, miss_cnt, m_rd, m_wr, m_hit, m_miss);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    apply(4'd1, 32'h0000_1000, 2'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 4'd1; addr = 32'h0000_2000; snoop_in = 2'd0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (rsp_valid !== 1'b0 || {read_cnt, write_cnt, hit_cnt, miss_cnt} !== '0) begin tests_failed++; $display("FAIL mid_reset: rsp=%0b cnt=%0d/%0d/%0d/%0d want 0", rsp_valid, read_cnt, write_cnt, hit_cnt, miss_cnt); end
    @(negedge clk);
    cmd_valid = 1'b0; rst_n = 1'b1;
    model_reset();
    apply(4'd0, 32'h0000_1000, 2'd0);
    tests_run++; if (miss !== 1'b1 || wb_valid !== 1'b0 || read_cnt !== 32'd1) begin tests_failed++; $display("FAIL mid_reset_miss: miss=%0b wb=%0b read_cnt=%0d want 1/0/1", miss, wb_valid, read_cnt); end
    apply(4'd0, 32'h0000_2000, 2'd0);
    tests_run++; if (miss !== 1'b1 || write_cnt !== 32'd0) begin tests_failed++; $display("FAIL mid_reset_discard: miss=%0b write_cnt=%0d want 1/0", miss, write_cnt); end
    idle();
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_shared_write();
    test_snoop();
    test_eviction();
    test_clear();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
